// File: rtl/alu_pkg.sv
// Shared definitions for the operand loader and the downstream ALU.
//
// Contents:
//   ALU_DATA_W / ALU_OP_W : default operand and opcode widths
//   loader_state_e        : operand loader FSM encoding (also drives the LEDs)
//   OPC_*                 : ALU opcode values, decoded by the downstream ALU
package alu_pkg;

    localparam int ALU_DATA_W = 8;
    localparam int ALU_OP_W   = 6;

    // Operand loader FSM states. The encoding is visible on the LEDs, so it is fixed.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HAVE_A = 2'd1,
        ST_HAVE_B = 2'd2,
        ST_READY  = 2'd3
    } loader_state_e;

    // ALU opcodes, 6 bits wide (funct-style encoding).
    localparam logic [ALU_OP_W-1:0] OPC_ADD  = 6'h20;
    localparam logic [ALU_OP_W-1:0] OPC_ADDU = 6'h21;
    localparam logic [ALU_OP_W-1:0] OPC_SUB  = 6'h22;
    localparam logic [ALU_OP_W-1:0] OPC_SUBU = 6'h23;
    localparam logic [ALU_OP_W-1:0] OPC_AND  = 6'h24;
    localparam logic [ALU_OP_W-1:0] OPC_OR   = 6'h25;
    localparam logic [ALU_OP_W-1:0] OPC_XOR  = 6'h26;
    localparam logic [ALU_OP_W-1:0] OPC_NOR  = 6'h27;
    localparam logic [ALU_OP_W-1:0] OPC_SLT  = 6'h2A;

endpackage

// File: rtl/button_debouncer.sv
// Conditions one raw push-button into a single-cycle press pulse.
//
// Ports:
//   clk     in  system clock, rising edge
//   rst_n   in  synchronous active-low reset
//   btn_raw in  raw bouncing button, asynchronous to clk
//   pulse   out one-cycle pulse on each accepted rising edge of the button
//
// The raw level goes through a 2-FF synchronizer. A counter measures how long
// the synchronized level has disagreed with the accepted level; after
// DEBOUNCE_CYCLES consecutive disagreeing samples the accepted level flips.
// A clean press therefore produces its pulse 2 + DEBOUNCE_CYCLES cycles later.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             level_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       settle_q;
    logic             armed_q, armed_d;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = sync2_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // A button already held at reset release must not produce a pulse.
        // Pulses are enabled only once the synchronizer has refilled and the
        // button has been seen released with the accepted level low.
        armed_d = armed_q | (settle_q[1] & ~level_q & ~sync2_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
            settle_q     <= 2'b00;
            armed_q      <= 1'b0;
        end else begin
            sync1_q      <= btn_raw;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
            settle_q     <= {settle_q[0], 1'b1};
            armed_q      <= armed_d;
        end
    end

    assign pulse = armed_q & level_q & ~level_prev_q;

endmodule

// File: rtl/operand_loader.sv
// Front-end for the ALU/adder datapath: latches operand A, operand B and the
// opcode from the switch bank in response to debounced button presses.
//
// Ports:
//   clk    in  system clock, rising edge
//   rst_n  in  synchronous active-low reset
//   sw     in  raw switch bank (DATA_W), asynchronous to clk
//   btn_a  in  raw button, load A (restarts the transaction)
//   btn_b  in  raw button, load B
//   btn_op in  raw button, load opcode
//   A, B   out latched operands (drive the adder inputs directly)
//   OP     out latched opcode, sw[OP_W-1:0]
//   valid  out high while A, B and OP are all loaded
//   state  out current FSM state (IDLE=0, HAVE_A=1, HAVE_B=2, READY=3)
//
// valid is a plain level with no ready: downstream logic may use A/B/OP in any
// cycle valid is high, and loses them only when a new A press restarts the
// sequence or reset is applied. B and OP may be re-entered while READY.
module operand_loader
    import alu_pkg::*;
#(
    parameter int DATA_W          = ALU_DATA_W,
    parameter int OP_W            = ALU_OP_W,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sw,
    input  logic              btn_a,
    input  logic              btn_b,
    input  logic              btn_op,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [OP_W-1:0]   OP,
    output logic              valid,
    output logic [1:0]        state
);

    logic              pa, pb, pop;
    logic [DATA_W-1:0] sw_s1_q, sw_sync_q;

    loader_state_e     state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              valid_q, valid_d;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_a),
        .pulse   (pa)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_b),
        .pulse   (pb)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_op (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_op),
        .pulse   (pop)
    );

    // Switches only need a plain 2-FF synchronizer: they are sampled long
    // after they settle, because a press takes DEBOUNCE_CYCLES to register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw_s1_q   <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_s1_q   <= sw;
            sw_sync_q <= sw_s1_q;
        end
    end

    // Only the highest-priority pulse acts (pa > pb > pop); the rest are dropped.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        valid_d = valid_q;
        if (pa) begin
            a_d     = sw_sync_q;
            state_d = ST_HAVE_A;
            valid_d = 1'b0;
        end else if (pb) begin
            case (state_q)
                ST_HAVE_A: begin
                    b_d     = sw_sync_q;
                    state_d = ST_HAVE_B;
                end
                ST_READY: begin
                    b_d = sw_sync_q;
                end
                default: ;
            endcase
        end else if (pop) begin
            case (state_q)
                ST_HAVE_B: begin
                    op_d    = sw_sync_q[OP_W-1:0];
                    state_d = ST_READY;
                    valid_d = 1'b1;
                end
                ST_READY: begin
                    op_d = sw_sync_q[OP_W-1:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            valid_q <= valid_d;
        end
    end

    assign A     = a_q;
    assign B     = b_q;
    assign OP    = op_q;
    assign valid = valid_q;
    assign state = state_q;

endmodule
